result_writeback: RTL
=====================

# result_writeback

Drains one finished N×N int8 result matrix into the unified result buffer, one row per write transaction. The block sits directly downstream of the result arranger: it captures the flat matrix when signalled, optionally applies ReLU per byte, and emits N row writes to consecutive addresses under a valid/ready handshake. It then pulses `done` so the controller can start the next tile.

## Interface
- `N`, 4: matrix dimension; rows written and bytes per row.
- `ADDR_W`, 8: result buffer address width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; `in_matrix`, `base_addr` and `relu_en` are valid in the same cycle.
- `in_matrix` input 8·N·N: flat matrix; row r = bits [8·N·(r+1)-1 : 8·N·r], byte c of row r = bits [8·(N·r+c)+7 : 8·(N·r+c)].
- `base_addr` input ADDR_W: buffer address for row 0.
- `relu_en` input 1: clamp negative bytes (signed int8) to 0.
- `wr_en` output 1: write valid.
- `wr_addr` output ADDR_W: row address.
- `wr_data` output 8·N: row payload, same byte order as an `in_matrix` row.
- `wr_ready` input 1: buffer accepts the write this cycle.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last row transfer.

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE: on `start`, latch `in_matrix`, `base_addr` and `relu_en`. Clear the row counter to 0 and go to WRITE.
- WRITE:
  - `wr_en` = 1.
  - `wr_addr` = latched base + row, modulo 2^ADDR_W; wrap-around is legal and silent.
  - `wr_data` = latched row `row`, passed through ReLU when the latched `relu_en` is set.
  - A transfer occurs when `wr_en && wr_ready`.
  - On transfer with row < N-1: increment row and stay in WRITE.
  - On transfer with row = N-1: go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- ReLU: each byte is treated as signed int8. Byte 0x80–0xFF becomes 0x00; 0x00–0x7F passes unchanged. No other arithmetic.
- `start` outside IDLE is ignored and does not disturb the latched data.
- `wr_addr` and `wr_data` are held stable while `wr_en` = 1 and `wr_ready` = 0. Upstream changes to `in_matrix` after the capture cycle have no effect.
- Row counter width is $clog2(N), with a minimum of 1 bit.

## Timing
- Reset values: `wr_en` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `done` 0. State goes to IDLE, row to 0, latched registers to 0.
- All outputs are registered or decoded from registered state only; none depend combinationally on `start` or `wr_ready`.
- With `start` at cycle 0 and `wr_ready` tied high:
  - `wr_en` is high cycles 1..N, rows 0..N-1.
  - `done` is high in cycle N+1.
  - `busy` is high cycles 1..N+1.
  - A new `start` is accepted in cycle N+2 or later.
- Each cycle of `wr_ready` = 0 during WRITE delays every subsequent event by one cycle.
- `reset` mid-transfer: the next cycle shows all outputs at reset values. No partial row is flagged and `done` is not pulsed.
- `start` and `reset` in the same cycle: reset wins.

## Structure
- Shared package `tpu_pkg`:
  - `DATA_W` = 8.
  - Enum `wb_state_t` {IDLE, WRITE, DONE}.
  - Function `row_slice(matrix, r)` for the row bit layout, shared with the arranger.
- Sub-module `relu_row #(N)`: purely combinational, N lanes of int8 clamp with an enable. `result_writeback` instantiates it once on the selected latched row.
- Top module holds the FSM, row counter, capture registers and output registers.

## Test plan
- **Basic drain:** N=4, byte (r,c) = 16·r+c, base 0x10, relu off, `wr_ready` = 1 → writes to 0x10..0x13 in cycles 1–4. Row 1 `wr_data` = 0x13121110. `done` pulses in cycle 5.
- **ReLU:** row 0 bytes {0x7F, 0x80, 0xFF, 0x01}, relu on → `wr_data` row 0 bytes {0x7F, 0x00, 0x00, 0x01}.
- **Backpressure:** `wr_ready` low for 3 cycles during row 2 → `wr_addr` and `wr_data` are held for 3 cycles. `done` is delayed to cycle 8, and no row is duplicated or dropped.
- **Address wrap:** base 0xFE, ADDR_W = 8 → addresses 0xFE, 0xFF, 0x00, 0x01.
- **Start while busy:** second `start` with different data in cycle 2 → ignored; all four rows carry the first matrix.
- **Reset mid-op:** `reset` in cycle 3 → cycle 4 shows `wr_en` = 0, `busy` = 0, and no `done` pulse. A fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared widths, writeback state encoding and the flat-matrix row layout helper
package tpu_pkg;
  localparam int DATA_W = 8;
  localparam int MAX_N = 16;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} wb_state_t;
  // Row r of an n x n matrix starts at bit DATA_W*n*r; callers size-cast to their own N.
  function automatic logic [DATA_W*MAX_N-1:0] row_slice(input logic [DATA_W*MAX_N*MAX_N-1:0] matrix, input int unsigned n, input int unsigned r);
    return (DATA_W*MAX_N)'(matrix >> (DATA_W*n*r));
  endfunction
endpackage

// File: rtl/result_writeback_if.sv
// result_writeback_if: row write channel into the unified result buffer
interface result_writeback_if #(parameter int N = 4, parameter int ADDR_W = 8) ();
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [tpu_pkg::DATA_W*N-1:0] wr_data;
  logic wr_ready;
  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/relu_row.sv
// relu_row: N-lane signed int8 clamp-to-zero with a shared enable
module relu_row import tpu_pkg::*; #(parameter int N = 4) (
  input  logic en,
  input  logic [DATA_W*N-1:0] row,
  output logic [DATA_W*N-1:0] clamped
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign clamped[DATA_W*i +: DATA_W] = en && row[DATA_W*i+DATA_W-1] ? '0 : row[DATA_W*i +: DATA_W];
  end
endmodule

// File: rtl/result_writeback.sv
// result_writeback: captures an N x N int8 matrix and drains it row by row into the result buffer
module result_writeback import tpu_pkg::*; #(
  parameter int N = 4,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [DATA_W*N*N-1:0] in_matrix,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic relu_en,
  result_writeback_if.master wr,
  output logic busy,
  output logic done
);
  localparam int RW = N > 1 ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST = RW'(N - 1);
  wb_state_t state_q, state_d;
  logic [RW-1:0] row_q;
  logic [DATA_W*N*N-1:0] mat_q;
  logic [ADDR_W-1:0] base_q;
  logic relu_q;
  logic [DATA_W*N-1:0] row_sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      mat_q <= '0;
      base_q <= '0;
      relu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        mat_q <= in_matrix;
        base_q <= base_addr;
        relu_q <= relu_en;
        row_q <= '0;
      end else if (state_q == WRITE && wr.wr_ready && row_q != LAST) begin
        row_q <= row_q + 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? WRITE : IDLE) :
              state_q == WRITE ? (wr.wr_ready && row_q == LAST ? DONE : WRITE) : IDLE;
  end
  assign row_sel = (DATA_W*N)'(row_slice((DATA_W*MAX_N*MAX_N)'(mat_q), N, 32'(row_q)));
  relu_row #(.N(N)) u_relu (.en(relu_q), .row(row_sel), .clamped(wr.wr_data));
  assign wr.wr_en = state_q == WRITE;
  assign wr.wr_addr = base_q + ADDR_W'(row_q);
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
